// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants (XLEN, NOP encoding, default reset PC) and a word-align helper
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~32'd3;
    endfunction
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register and next-PC mux (redirect > stall > +4); alignment set by IF_ALIGN_CHECK_EN
module pc_reg
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);
    logic [XLEN-1:0] pc_q, pc_d, target;

    // redirect target: raw address with alignment checking, forced to a word boundary otherwise
    always_comb begin
`ifdef IF_ALIGN_CHECK_EN
        target = redirect_pc;
`else
        target = word_align(redirect_pc);
`endif
        pc_d = redirect ? target : stall ? pc_q : pc_q + 32'd4;
    end

    // PC register, asynchronously forced to RESET_PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with IF/ID register; IF_ALIGN_CHECK_EN enables the misalign flag
module if_stage
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              IM_AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IM_AW-1:0] im_addr,
    input  logic [XLEN-1:0]  im_inst,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  id_inst,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_pc4,
    output logic             id_valid,
    output logic             misalign
);
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] id_inst_q, id_inst_d, id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
    logic            id_valid_q, id_valid_d;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
    );

    assign im_addr = pc[IM_AW+1:2];

    // IF/ID next state: redirect/flush insert a NOP bubble, stall holds, otherwise capture the fetch
    always_comb begin
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        if (redirect || flush) begin
            id_inst_d  = NOP;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_inst_d  = im_inst;
            id_pc_d    = pc;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
        end
    end

    // IF/ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_inst_q  <= NOP;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
        end else begin
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign id_inst  = id_inst_q;
    assign id_pc    = id_pc_q;
    assign id_pc4   = id_pc4_q;
    assign id_valid = id_valid_q;

`ifdef IF_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // misalign captures the low bits of each redirect target and clears once the PC moves on
    always_comb begin
        misalign_d = redirect ? |redirect_pc[1:0] : stall ? misalign_q : 1'b0;
    end

    // misalign flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table plus randomized run against a behavioural fetch model
module tb_if_stage;
    import rv32i_pkg::*;

    localparam bit ALN = `ifdef IF_ALIGN_CHECK_EN 1'b1 `else 1'b0 `endif ;
    localparam logic [31:0] P7 = ALN ? 32'h7E : 32'h7C;

    typedef struct {
        logic        st, fl, rd;
        logic [31:0] rpc;
        logic [31:0] pc, inst, idpc;
        logic        v, mis, chk_pc;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [4:0]  im_addr;
    logic [31:0] im_inst;
    logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc, id_inst, id_pc, id_pc4;
    logic        id_valid, misalign;
    logic [31:0] mem [32];
    int          n_chk = 0, n_fail = 0;
    vec_t        tv [$];

    assign im_inst = mem[im_addr];

    if_stage #(.RESET_PC(32'h0), .IM_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_inst(im_inst),
        .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .pc(pc), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
        .id_valid(id_valid), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
        stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, fl, rd, input logic [31:0] rpc, epc, einst, eidpc,
                                input logic ev, emis, ec);
        vec_t t;
        t.st = st; t.fl = fl; t.rd = rd; t.rpc = rpc;
        t.pc = epc; t.inst = einst; t.idpc = eidpc; t.v = ev; t.mis = emis; t.chk_pc = ec;
        return t;
    endfunction

    // behavioural model state
    logic [31:0] m_pc, m_inst, m_idpc;
    logic        m_v, m_mis;

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 + k;
        tv.push_back(mk(0,0,0,0,          32'h4,  32'h1000_0000, 32'h0,  1,0,1));
        tv.push_back(mk(0,0,0,0,          32'h8,  32'h1000_0001, 32'h4,  1,0,1));
        tv.push_back(mk(1,0,0,0,          32'h8,  32'h1000_0001, 32'h4,  1,0,1));
        tv.push_back(mk(1,0,0,0,          32'h8,  32'h1000_0001, 32'h4,  1,0,1));
        tv.push_back(mk(1,0,0,0,          32'h8,  32'h1000_0001, 32'h4,  1,0,1));
        tv.push_back(mk(0,0,0,0,          32'hC,  32'h1000_0002, 32'h8,  1,0,1));
        tv.push_back(mk(0,0,0,0,          32'h10, 32'h1000_0003, 32'hC,  1,0,1));
        tv.push_back(mk(0,1,0,0,          32'h14, NOP,           32'h0,  0,0,0));
        tv.push_back(mk(0,0,0,0,          32'h18, 32'h1000_0005, 32'h14, 1,0,1));
        tv.push_back(mk(1,0,1,32'h40,     32'h40, NOP,           32'h0,  0,0,0));
        tv.push_back(mk(0,0,0,0,          32'h44, 32'h1000_0010, 32'h40, 1,0,1));
        tv.push_back(mk(0,0,1,32'h7E,     P7,     NOP,           32'h0,  0,ALN,0));
        tv.push_back(mk(1,0,0,0,          P7,     NOP,           32'h0,  0,ALN,0));
        tv.push_back(mk(0,0,0,0,          P7+4,   32'h1000_001F, P7,     1,0,1));
        tv.push_back(mk(1,1,0,0,          P7+4,   NOP,           32'h0,  0,0,0));
        tv.push_back(mk(0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,   32'h0,  0,0,0));
        tv.push_back(mk(0,0,0,0,          32'h0,  32'h1000_001F, 32'hFFFF_FFFC, 1,0,1));
        tv.push_back(mk(0,0,0,0,          32'h4,  32'h1000_0000, 32'h0,  1,0,1));

        // reset state while rst_n is held low
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_im_addr", {27'd0, im_addr}, 32'h0);
        chk("rst_id_inst", id_inst, NOP);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc4", id_pc4, 32'h0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'h0);
        chk("rst_misalign", {31'd0, misalign}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vector table
        foreach (tv[i]) begin
            drive(tv[i].st, tv[i].fl, tv[i].rd, tv[i].rpc);
            step();
            chk($sformatf("v%0d_pc", i), pc, tv[i].pc);
            chk($sformatf("v%0d_im_addr", i), {27'd0, im_addr}, {27'd0, tv[i].pc[6:2]});
            chk($sformatf("v%0d_id_inst", i), id_inst, tv[i].inst);
            chk($sformatf("v%0d_id_valid", i), {31'd0, id_valid}, {31'd0, tv[i].v});
            chk($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, tv[i].mis});
            if (tv[i].chk_pc) begin
                chk($sformatf("v%0d_id_pc", i), id_pc, tv[i].idpc);
                chk($sformatf("v%0d_id_pc4", i), id_pc4, tv[i].idpc + 32'd4);
            end
        end

        // asynchronous reset between edges at pc=0x20
        drive(0,0,0,0);
        for (int k = 0; k < 7; k++) step();
        chk("pre_async_pc", pc, 32'h20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_id_valid", {31'd0, id_valid}, 32'h0);
        chk("async_id_inst", id_inst, NOP);
        #1;
        rst_n = 1'b1;
        // first edge after release with stall high keeps the bubble, next edge fetches RESET_PC
        drive(1,0,0,0);
        step();
        chk("post_rst_stall_pc", pc, 32'h0);
        chk("post_rst_stall_valid", {31'd0, id_valid}, 32'h0);
        drive(0,0,0,0);
        step();
        chk("post_rst_pc", pc, 32'h4);
        chk("post_rst_inst", id_inst, 32'h1000_0000);
        chk("post_rst_valid", {31'd0, id_valid}, 32'h1);

        // randomized run against the model
        for (int k = 0; k < 32; k++) mem[k] = $urandom;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_pc = 32'h0; m_inst = NOP; m_idpc = 32'h0; m_v = 1'b0; m_mis = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic st, fl, rd;
            logic [31:0] rpc, tgt;
            st = ($urandom % 4) == 0;
            fl = ($urandom % 8) == 0;
            rd = ($urandom % 10) == 0;
            case ($urandom % 4)
                0: rpc = $urandom;
                1: rpc = 32'hFFFF_FFFC;
                2: rpc = $urandom & 32'h7F;
                default: rpc = 32'hFFFF_FFF8 | ($urandom & 32'h3);
            endcase
            if (n % 50 == 0) mem[$urandom % 32] = $urandom;
            drive(st, fl, rd, rpc);
            tgt = ALN ? rpc : (rpc / 4) * 4;
            if (rd) begin
                m_pc = tgt; m_v = 1'b0; m_inst = NOP; m_mis = ALN && (rpc % 4 != 0);
            end else if (fl) begin
                m_v = 1'b0; m_inst = NOP;
                if (!st) begin m_pc = m_pc + 4; m_mis = 1'b0; end
            end else if (!st) begin
                m_inst = mem[(m_pc / 4) % 32]; m_idpc = m_pc; m_v = 1'b1;
                m_pc = m_pc + 4; m_mis = 1'b0;
            end
            step();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_im_addr", {27'd0, im_addr}, (m_pc / 4) % 32);
            chk("rnd_id_inst", id_inst, m_inst);
            chk("rnd_id_valid", {31'd0, id_valid}, {31'd0, m_v});
            chk("rnd_misalign", {31'd0, misalign}, {31'd0, m_mis});
            if (m_v) begin
                chk("rnd_id_pc", id_pc, m_idpc);
                chk("rnd_id_pc4", id_pc4, m_idpc + 4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
